wavegen_adsr: RTL and testbench

// - Per-voice ADSR envelope generator for the audio wavegen path. Produces an 8-bit

---
 rtl/wavegen_adsr.sv | 176 +++++++++++++++++
 tb/tb_wavegen_adsr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wavegen_adsr.sv
// Per-voice ADSR envelope generator, 8.16 accumulator stepped on each sample strobe.
// Define WAVEGEN_ADSR_EXP_EN for level-dependent (exponential-like) decay and release steps.
module wavegen_adsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_strobe,
  input  logic [3:0] attack,
  input  logic [3:0] decay,
  input  logic [3:0] sustain,
  input  logic [3:0] release_rate,
  input  logic       gate,
  output logic [7:0] envelope_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [24:0] FULL_SCALE = 25'h0FF0000;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] acc;
  logic [23:0] acc_nxt;
  logic [23:0] sus_lvl;
  logic [23:0] dr_step;
  logic [3:0]  dr_idx;
  logic [24:0] sum;
  logic [24:0] diff;

  function automatic logic [23:0] a_inc(input logic [3:0] idx);
    case (idx)
      4'd0:    a_inc = 24'd174080;
      4'd1:    a_inc = 24'd43520;
      4'd2:    a_inc = 24'd21760;
      4'd3:    a_inc = 24'd14507;
      4'd4:    a_inc = 24'd9162;
      4'd5:    a_inc = 24'd6217;
      4'd6:    a_inc = 24'd5120;
      4'd7:    a_inc = 24'd4352;
      4'd8:    a_inc = 24'd3482;
      4'd9:    a_inc = 24'd1393;
      4'd10:   a_inc = 24'd696;
      4'd11:   a_inc = 24'd435;
      4'd12:   a_inc = 24'd348;
      4'd13:   a_inc = 24'd116;
      4'd14:   a_inc = 24'd70;
      4'd15:   a_inc = 24'd44;
      default: a_inc = 24'd44;
    endcase
  endfunction

  function automatic logic [23:0] dr_inc(input logic [3:0] idx);
    case (idx)
      4'd0:    dr_inc = 24'd58027;
      4'd1:    dr_inc = 24'd14507;
      4'd2:    dr_inc = 24'd7253;
      4'd3:    dr_inc = 24'd4836;
      4'd4:    dr_inc = 24'd3054;
      4'd5:    dr_inc = 24'd2072;
      4'd6:    dr_inc = 24'd1707;
      4'd7:    dr_inc = 24'd1451;
      4'd8:    dr_inc = 24'd1161;
      4'd9:    dr_inc = 24'd464;
      4'd10:   dr_inc = 24'd232;
      4'd11:   dr_inc = 24'd145;
      4'd12:   dr_inc = 24'd116;
      4'd13:   dr_inc = 24'd39;
      4'd14:   dr_inc = 24'd23;
      4'd15:   dr_inc = 24'd15;
      default: dr_inc = 24'd15;
    endcase
  endfunction

`ifdef WAVEGEN_ADSR_EXP_EN
  function automatic logic [2:0] exp_shift(input logic [7:0] env);
    if (env >= 8'd94)      exp_shift = 3'd0;
    else if (env >= 8'd54) exp_shift = 3'd1;
    else if (env >= 8'd26) exp_shift = 3'd2;
    else if (env >= 8'd14) exp_shift = 3'd3;
    else if (env >= 8'd6)  exp_shift = 3'd4;
    else                   exp_shift = 3'd5;
  endfunction
`endif

  // Step size and candidate accumulator values for the current phase
  always_comb begin
    sus_lvl = {sustain, sustain, 16'h0000};
    dr_idx  = (state == RELEASE) ? release_rate : decay;
`ifdef WAVEGEN_ADSR_EXP_EN
    dr_step = dr_inc(dr_idx) >> exp_shift(acc[23:16]);
    if (dr_step == 24'd0) begin
      dr_step = 24'd1;
    end else begin
      dr_step = dr_step;
    end
`else
    dr_step = dr_inc(dr_idx);
`endif
    sum  = {1'b0, acc} + {1'b0, a_inc(attack)};
    diff = {1'b0, acc} - {1'b0, dr_step};
  end

  // Phase sequencing; a gate change takes one strobe and leaves acc untouched
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    if (sample_strobe) begin
      case (state)
        IDLE: begin
          if (gate) state_nxt = ATTACK;
          else      state_nxt = IDLE;
        end
        ATTACK: begin
          if (!gate) begin
            state_nxt = RELEASE;
          end else if (sum >= FULL_SCALE) begin
            acc_nxt   = FULL_SCALE[23:0];
            state_nxt = DECAY;
          end else begin
            acc_nxt = sum[23:0];
          end
        end
        DECAY: begin
          if (!gate) begin
            state_nxt = RELEASE;
          end else if (diff[24] || (diff[23:0] <= sus_lvl)) begin
            acc_nxt   = sus_lvl;
            state_nxt = SUSTAIN;
          end else begin
            acc_nxt = diff[23:0];
          end
        end
        SUSTAIN: begin
          if (!gate) state_nxt = RELEASE;
          else       acc_nxt   = sus_lvl;
        end
        RELEASE: begin
          if (gate) begin
            state_nxt = ATTACK;
          end else if (diff[24] || (diff[23:0] == 24'd0)) begin
            acc_nxt   = 24'd0;
            state_nxt = IDLE;
          end else begin
            acc_nxt = diff[23:0];
          end
        end
        default: begin
          acc_nxt   = 24'd0;
          state_nxt = IDLE;
        end
      endcase
    end else begin
      state_nxt = state;
      acc_nxt   = acc;
    end
  end

  // State, accumulator and registered envelope output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= 24'd0;
      envelope_out <= 8'd0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      envelope_out <= acc_nxt[23:16];
    end
  end

endmodule

// File: tb/tb_wavegen_adsr.sv
// Scoreboard bench for wavegen_adsr (linear build): stimulus queues expected env/state per strobe.
module tb_wavegen_adsr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_strobe = 1'b0;
  logic [3:0] attack = 4'd0;
  logic [3:0] decay = 4'd0;
  logic [3:0] sustain = 4'd0;
  logic [3:0] release_rate = 4'd0;
  logic       gate = 1'b0;
  logic [7:0] envelope_out;

  wavegen_adsr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_strobe(sample_strobe),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
    .gate         (gate),
    .envelope_out (envelope_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    logic [7:0] env;
    logic [2:0] st;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cmp(input string name, input logic [7:0] act_env, input logic [2:0] act_st,
                     input logic [7:0] exp_env, input logic [2:0] exp_st);
    vectors++;
    if (act_env !== exp_env || act_st !== exp_st) begin
      miscompares++;
      $display("FAIL %s: got env=%0d state=%0d, expected env=%0d state=%0d",
               name, act_env, act_st, exp_env, exp_st);
    end
  endtask

  // Monitor: every strobe is an output event; pop its expectation and compare
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && sample_strobe) begin
      #1;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got a strobe with no expectation queued");
      end else begin
        e = sbq.pop_front();
        if (e.chk) cmp(e.name, envelope_out, 3'(dut.state), e.env, e.st);
      end
    end
  end

  task automatic strobe(input bit chk, input logic [7:0] env, input logic [2:0] st, input string name);
    exp_t e;
    @(negedge clk);
    e.chk = chk; e.env = env; e.st = st; e.name = name;
    sbq.push_back(e);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic run(input int n, input logic [7:0] env, input logic [2:0] st, input string name);
    for (int i = 1; i <= n; i++) strobe(i == n, env, st, name);
  endtask

  initial begin
    #22 rst_n = 1'b1;
    cmp("reset_state", envelope_out, 3'(dut.state), 8'd0, 3'd0);

    // async reset in the middle of ATTACK
    attack = 4'd1; gate = 1'b1;
    strobe(1'b1, 8'd0, 3'd1, "idle_to_attack");
    run(10, 8'd6, 3'd1, "attack_10");
    @(posedge clk); #3 rst_n = 1'b0;
    #1 cmp("async_reset", envelope_out, 3'(dut.state), 8'd0, 3'd0);
    @(negedge clk); rst_n = 1'b1;

    // full cycle A=1 D=2 S=8 R=3
    decay = 4'd2; sustain = 4'd8; release_rate = 4'd3; gate = 1'b1;
    strobe(1'b1, 8'd0, 3'd1, "full_start");
    run(383, 8'd254, 3'd1, "attack_383");
    strobe(1'b1, 8'd255, 3'd2, "attack_peak");
    run(1075, 8'd136, 3'd2, "decay_1075");
    strobe(1'b1, 8'd136, 3'd3, "decay_to_sustain");
    run(20, 8'd136, 3'd3, "sustain_hold");
    gate = 1'b0;
    strobe(1'b1, 8'd136, 3'd4, "sustain_to_release");
    run(1843, 8'd0, 3'd4, "release_1843");
    strobe(1'b1, 8'd0, 3'd0, "release_to_idle");

    // retrigger from partial release
    gate = 1'b1;
    strobe(1'b1, 8'd0, 3'd1, "rt_start");
    run(384, 8'd255, 3'd2, "rt_setup_peak");
    run(1076, 8'd136, 3'd3, "rt_setup_sustain");
    gate = 1'b0;
    strobe(1'b1, 8'd136, 3'd4, "rt_to_release");
    run(30, 8'd133, 3'd4, "rt_release_30");
    gate = 1'b1;
    strobe(1'b1, 8'd133, 3'd1, "retrigger");
    strobe(1'b1, 8'd134, 3'd1, "rt_attack_1");
    run(181, 8'd254, 3'd1, "rt_attack_182");
    strobe(1'b1, 8'd255, 3'd2, "rt_peak");
    run(1076, 8'd136, 3'd3, "rt_sustain");

    // sustain level tracks live input
    sustain = 4'd4;
    strobe(1'b1, 8'd68, 3'd3, "sustain_live_68");
    sustain = 4'd8;
    strobe(1'b1, 8'd136, 3'd3, "sustain_live_136");

    // fast A=0 D=0 S=8 R=0
    attack = 4'd0; decay = 4'd0; release_rate = 4'd0; gate = 1'b0;
    strobe(1'b1, 8'd136, 3'd4, "fast_pre_release");
    run(153, 8'd0, 3'd4, "fast_pre_rel_153");
    strobe(1'b1, 8'd0, 3'd0, "fast_pre_idle");
    gate = 1'b1;
    strobe(1'b1, 8'd0, 3'd1, "fast_start");
    run(95, 8'd252, 3'd1, "fast_attack_95");
    strobe(1'b1, 8'd255, 3'd2, "fast_peak");
    run(134, 8'd136, 3'd2, "fast_decay_134");
    strobe(1'b1, 8'd136, 3'd3, "fast_sustain");

    // gate toggling without strobes changes nothing
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      gate = ~gate;
      if (i % 100 == 0) cmp("no_strobe_hold", envelope_out, 3'(dut.state), 8'd136, 3'd3);
    end

    gate = 1'b0;
    strobe(1'b1, 8'd136, 3'd4, "fast_release");
    run(153, 8'd0, 3'd4, "fast_release_153");
    strobe(1'b1, 8'd0, 3'd0, "fast_idle");

    // zero sustain A=1 D=1 S=0 R=1
    attack = 4'd1; decay = 4'd1; sustain = 4'd0; release_rate = 4'd1; gate = 1'b1;
    strobe(1'b1, 8'd0, 3'd1, "zs_start");
    run(384, 8'd255, 3'd2, "zs_peak");
    run(1151, 8'd0, 3'd2, "zs_decay_1151");
    strobe(1'b1, 8'd0, 3'd3, "zs_sustain");
    gate = 1'b0;
    strobe(1'b1, 8'd0, 3'd4, "zs_release");
    strobe(1'b1, 8'd0, 3'd0, "zs_idle");

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_leftover: %0d expectations never matched, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
